// File: rtl/rom_string_sender_if.sv
// ROM read port and UART TX handshake bundled for the string sender.
// master = sequencer side, slave = ROM/UART side.
interface rom_string_sender_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport master (
    output addr, tx_data, tx_start,
    input  mem_data, tx_busy
  );

  modport slave (
    input  addr, tx_data, tx_start,
    output mem_data, tx_busy
  );
endinterface

// File: rtl/rom_string_sender.sv
// Streams a null-terminated string from a synchronous ROM into a UART TX,
// one byte per frame, stopping at the null or at the top ROM address.
//
// state | meaning
// IDLE  | waiting for start_i
// FETCH | ROM read latency cycle
// CHECK | null test, wait on UART busy, issue strobe
// GUARD | drop strobe, advance address or finish at top
// DONE  | done_o high, busy_o low, rewind address
module rom_string_sender #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  rom_string_sender_if.master bus,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_GUARD = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  logic [2:0] state;

  // done_o/busy_o are updated on entry to DONE so the pulse and the busy
  // fall line up with the DONE cycle itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      bus.addr     <= BASE_ADDR;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            bus.addr <= BASE_ADDR;
            busy_o   <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (bus.mem_data == '0) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_DONE;
          end else if (!bus.tx_busy) begin
            bus.tx_data  <= bus.mem_data;
            bus.tx_start <= 1'b1;
            state        <= S_GUARD;
          end
        end
        S_GUARD: begin
          bus.tx_start <= 1'b0;
          // No wrap: an unterminated ROM ends after its top byte.
          if (bus.addr == TOP_ADDR) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_DONE;
          end else begin
            bus.addr <= bus.addr + 1'b1;
            state    <= S_FETCH;
          end
        end
        S_DONE: begin
          bus.addr <= BASE_ADDR;
          state    <= S_IDLE;
        end
        default: begin
          bus.tx_start <= 1'b0;
          busy_o       <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_string_sender.sv
// Directed bench for rom_string_sender: ROM + UART models, one task per scenario.
module tb_rom_string_sender;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start2, force_busy;
  logic busy, done, busy2, done2;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] rom  [16];
  logic [7:0] rom2 [16];
  int    busy_cnt = 0;
  string exp_str  = "Simple UART EyC";

  rom_string_sender_if #(.ADDR_W(4), .DATA_W(8)) bus ();
  rom_string_sender_if #(.ADDR_W(4), .DATA_W(8)) bus2 ();

  rom_string_sender #(.ADDR_W(4), .DATA_W(8), .BASE_ADDR(4'd0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bus(bus),
    .busy_o(busy), .done_o(done));

  rom_string_sender #(.ADDR_W(4), .DATA_W(8), .BASE_ADDR(4'd15)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .bus(bus2),
    .busy_o(busy2), .done_o(done2));

  // synchronous ROMs and a UART that stays busy 10 cycles per frame
  always @(posedge clk) begin
    bus.mem_data  <= rom[bus.addr];
    bus2.mem_data <= rom2[bus2.addr];
  end

  always @(posedge clk) begin
    if (bus.tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  assign bus.tx_busy  = force_busy | (busy_cnt != 0);
  assign bus2.tx_busy = 1'b0;

  logic [7:0] got [$];
  int n_done = 0, n_consec = 0, n_wrap = 0, n_strobe2 = 0;
  int cyc = 0, last_strobe_cyc = 0, done_cyc = 0;
  bit prev_start = 0, seen15 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_start) begin
      got.push_back(bus.tx_data);
      last_strobe_cyc = cyc;
    end
    if (bus.tx_start && prev_start) n_consec++;
    prev_start = bus.tx_start;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus2.tx_start) n_strobe2++;
    if (busy) begin
      if (bus.addr == 4'd15) seen15 = 1;
      else if (seen15 && bus.addr == 4'd0) n_wrap++;
    end else begin
      seen15 = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    n_done = 0; n_consec = 0; n_wrap = 0; n_strobe2 = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    int cnt = 0;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_start) cnt++;
      if (cnt == n) begin ok = 1; break; end
    end
  endtask

  task automatic load_string();
    for (int i = 0; i < 16; i++) rom[i] = (i < 15) ? 8'(exp_str[i]) : 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; force_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin rom[i] = 8'h00; rom2[i] = 8'h00; end
    tick(2);
    n_cmp++; if (bus.addr !== 4'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", bus.addr); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    n_cmp++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start got %b want 0", bus.tx_start); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (bus2.addr !== 4'd15) begin n_err++; $display("FAIL reset_addr_base15 got %0d want 15", bus2.addr); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_full_string();
    bit ok;
    load_string();
    tick(1);
    clear_mon();
    pulse_start();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy_rise got %b want 1", busy); end
    n_cmp++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL full_no_strobe_fetch got %b want 0", bus.tx_start); end
    @(negedge clk);
    n_cmp++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL full_no_strobe_check got %b want 0", bus.tx_start); end
    @(negedge clk);
    n_cmp++; if (bus.tx_start !== 1'b1) begin n_err++; $display("FAIL full_first_strobe_n3 got %b want 1", bus.tx_start); end
    n_cmp++; if (bus.tx_data !== 8'h53) begin n_err++; $display("FAIL full_first_data got %h want 53", bus.tx_data); end
    wait_done(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL full_done_timeout got %b want 1", ok); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_at_done got %b want 0", busy); end
    tick(5);
    n_cmp++; if (got.size() !== 15) begin n_err++; $display("FAIL full_strobe_count got %0d want 15", got.size()); end
    for (int i = 0; i < 15; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== 8'(exp_str[i])) begin
        n_err++;
        $display("FAIL full_byte[%0d] got %h want %h", i, (i < got.size()) ? got[i] : 8'h00, 8'(exp_str[i]));
      end
    end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL full_done_count got %0d want 1", n_done); end
    n_cmp++; if (n_consec !== 0) begin n_err++; $display("FAIL full_consec_strobe got %0d want 0", n_consec); end
    n_cmp++; if (bus.tx_data !== 8'h43) begin n_err++; $display("FAIL full_data_held got %h want 43", bus.tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_after got %b want 0", busy); end
  endtask

  task automatic test_empty();
    rom2[15] = 8'h00;
    tick(1);
    clear_mon();
    start2 = 1'b1; tick(1); start2 = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL empty_busy_n1 got %b want 1", busy2); end
    n_cmp++; if (done2 !== 1'b0) begin n_err++; $display("FAIL empty_done_n1 got %b want 0", done2); end
    @(negedge clk);
    n_cmp++; if (done2 !== 1'b0) begin n_err++; $display("FAIL empty_done_n2 got %b want 0", done2); end
    @(negedge clk);
    n_cmp++; if (done2 !== 1'b1) begin n_err++; $display("FAIL empty_done_n3 got %b want 1", done2); end
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL empty_busy_n3 got %b want 0", busy2); end
    @(negedge clk);
    n_cmp++; if (done2 !== 1'b0) begin n_err++; $display("FAIL empty_done_pulse got %b want 0", done2); end
    tick(3);
    n_cmp++; if (n_strobe2 !== 0) begin n_err++; $display("FAIL empty_strobes got %0d want 0", n_strobe2); end
  endtask

  task automatic test_top_single();
    rom2[15] = 8'h5A;
    tick(1);
    clear_mon();
    start2 = 1'b1; tick(1); start2 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus2.tx_start !== 1'b1) begin n_err++; $display("FAIL top_strobe got %b want 1", bus2.tx_start); end
    n_cmp++; if (bus2.tx_data !== 8'h5A) begin n_err++; $display("FAIL top_data got %h want 5a", bus2.tx_data); end
    @(negedge clk);
    n_cmp++; if (done2 !== 1'b1) begin n_err++; $display("FAIL top_done_after_guard got %b want 1", done2); end
    tick(5);
    n_cmp++; if (n_strobe2 !== 1) begin n_err++; $display("FAIL top_strobes got %0d want 1", n_strobe2); end
    rom2[15] = 8'h00;
  endtask

  task automatic test_back_to_back();
    bit ok = 0;
    int zeros = 0;
    start2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done2) begin ok = 1; break; end
    end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b want 1", ok); end
    repeat (3) begin
      @(negedge clk);
      if (done2 === 1'b0) zeros++;
    end
    n_cmp++; if (zeros !== 3) begin n_err++; $display("FAIL b2b_gap got %0d want 3", zeros); end
    @(negedge clk);
    n_cmp++; if (done2 !== 1'b1) begin n_err++; $display("FAIL b2b_restart_done got %b want 1", done2); end
    tick(1);
    start2 = 1'b0;
    tick(6);
  endtask

  task automatic test_back_pressure();
    bit ok;
    int early = 0, bad = 0;
    load_string();
    force_busy = 1'b1;
    tick(1);
    clear_mon();
    pulse_start();
    repeat (50) begin
      @(negedge clk);
      if (bus.tx_start !== 1'b0) early++;
    end
    tick(1);
    force_busy = 1'b0;
    @(negedge clk);
    if (bus.tx_start !== 1'b0) early++;
    n_cmp++; if (early !== 0) begin n_err++; $display("FAIL bp_strobe_while_busy got %0d want 0", early); end
    @(negedge clk);
    n_cmp++; if (bus.tx_start !== 1'b1) begin n_err++; $display("FAIL bp_strobe_after_drop got %b want 1", bus.tx_start); end
    n_cmp++; if (bus.tx_data !== 8'h53) begin n_err++; $display("FAIL bp_first_data got %h want 53", bus.tx_data); end
    wait_done(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_done_timeout got %b want 1", ok); end
    tick(3);
    for (int i = 0; i < 15; i++)
      if (i >= got.size() || got[i] !== 8'(exp_str[i])) bad++;
    n_cmp++; if (got.size() !== 15 || bad !== 0) begin n_err++; $display("FAIL bp_sequence got %0d bytes %0d wrong want 15 bytes 0 wrong", got.size(), bad); end
  endtask

  task automatic test_unterminated();
    bit ok;
    int bad = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h41;
    tick(1);
    clear_mon();
    pulse_start();
    wait_done(3000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL unterm_done_timeout got %b want 1", ok); end
    tick(3);
    n_cmp++; if (got.size() !== 16) begin n_err++; $display("FAIL unterm_strobe_count got %0d want 16", got.size()); end
    foreach (got[i]) if (got[i] !== 8'h41) bad++;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL unterm_bytes got %0d wrong want 0", bad); end
    n_cmp++; if (n_wrap !== 0) begin n_err++; $display("FAIL unterm_wrap got %0d want 0", n_wrap); end
    n_cmp++; if (done_cyc - last_strobe_cyc !== 1) begin n_err++; $display("FAIL unterm_done_after_guard got %0d want 1", done_cyc - last_strobe_cyc); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL unterm_done_count got %0d want 1", n_done); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int bad = 0;
    load_string();
    tick(1);
    clear_mon();
    pulse_start();
    wait_strobes(5, 500, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ign_wait_5th got %b want 1", ok); end
    tick(1);
    pulse_start();
    wait_done(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ign_done_timeout got %b want 1", ok); end
    tick(40);
    for (int i = 0; i < 15; i++)
      if (i >= got.size() || got[i] !== 8'(exp_str[i])) bad++;
    n_cmp++; if (got.size() !== 15 || bad !== 0) begin n_err++; $display("FAIL ign_sequence got %0d bytes %0d wrong want 15 bytes 0 wrong", got.size(), bad); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL ign_done_count got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    load_string();
    tick(1);
    clear_mon();
    pulse_start();
    wait_strobes(5, 500, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid_wait_5th got %b want 1", ok); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_start got %b want 0", bus.tx_start); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (bus.addr !== 4'd0) begin n_err++; $display("FAIL rstmid_addr got %0d want 0", bus.addr); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_tx_data got %h want 00", bus.tx_data); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL rstmid_no_done got %0d want 0", n_done); end
    clear_mon();
    pulse_start();
    wait_done(2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid_done_timeout got %b want 1", ok); end
    tick(3);
    n_cmp++; if (got.size() !== 15) begin n_err++; $display("FAIL rstmid_count got %0d want 15", got.size()); end
    n_cmp++; if (got.size() == 0 || got[0] !== 8'h53) begin n_err++; $display("FAIL rstmid_first_byte got %h want 53", (got.size() > 0) ? got[0] : 8'h00); end
  endtask

  initial begin
    test_reset();
    test_full_string();
    test_empty();
    test_top_single();
    test_back_to_back();
    test_back_pressure();
    test_unterminated();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
